ysyx_23060203_ifu: RTL and testbench

Instruction fetch unit: the upstream producer of the IDU's `in_valid/in_ready/in_pc/in_inst` handshake and the consumer of its `jump_flush/jump_dnpc` redirect. It issues single-outstanding word reads to instruction memory and predecodes each returned word with the same static prediction the IDU checks against. It buffers fetched instructions in a 2-entry queue and discards wrong-path work on any redirect.

---
 rtl/ysyx_23060203_ifu_if.sv | 24 ++
 rtl/ysyx_23060203_ifu.sv | 169 ++++++++++++++++
 tb/tb_ysyx_23060203_ifu.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_ifu_if.sv
// Instruction-memory bus and IFU->IDU instruction handshake bundled for the IFU.
// valid/ready: a transfer happens on a clock edge where both are high; a raised valid holds its payload until that edge.
interface ysyx_23060203_ifu_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   modport master (
      output mem_req_valid, mem_req_addr, mem_resp_ready, out_valid, out_pc, out_inst,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_resp_ready, out_valid, out_pc, out_inst,
      output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready
   );
endinterface

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: single-outstanding word fetch, static next-PC prediction,
// 2-entry {pc, inst} queue toward the IDU, wrong-path discard on flush/jump redirect.
module ysyx_23060203_ifu #(
   parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [31:0]               flush_dnpc,
   input  logic                      jump_flush,
   input  logic [31:0]               jump_dnpc,
   ysyx_23060203_ifu_if.master       bus,
   output logic [1:0]                dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        drop_q, drop_d;
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic [31:0] fifo_pc_q   [2];
   logic [31:0] fifo_inst_q [2];

   logic        redirect;
   logic [31:0] target;
   logic        resp_fire;
   logic        out_valid_w;
   logic        enq;
   logic        deq;
   logic        wr_ptr;
   logic [31:0] pred_pc;
   logic [31:0] next_fetch;
   logic [31:0] imm_j;
   logic [31:0] imm_b;
   logic [4:0]  opcode;

   assign redirect    = flush | jump_flush;
   assign target      = flush ? flush_dnpc : jump_dnpc;
   assign resp_fire   = (state_q == S_WAIT) & bus.mem_resp_valid;
   assign out_valid_w = (count_q != 2'd0) & ~redirect;
   assign deq         = out_valid_w & bus.out_ready;
   // A redirect cycle's response is wrong-path even when drop is still clear.
   assign enq         = resp_fire & ~drop_q & ~redirect;
   assign wr_ptr      = head_q ^ count_q[0];

   assign opcode = bus.mem_resp_data[6:2];
   assign imm_j  = {{12{bus.mem_resp_data[31]}}, bus.mem_resp_data[19:12],
                    bus.mem_resp_data[20], bus.mem_resp_data[30:21], 1'b0};
   assign imm_b  = {{20{bus.mem_resp_data[31]}}, bus.mem_resp_data[7],
                    bus.mem_resp_data[30:25], bus.mem_resp_data[11:8], 1'b0};

   always_comb begin
      pred_pc = req_addr_q + 32'd4;
      if (opcode == 5'b11011) begin
         pred_pc = req_addr_q + imm_j;
      end else if ((opcode == 5'b11000) && bus.mem_resp_data[31]) begin
         pred_pc = req_addr_q + imm_b;
      end
   end

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      if (redirect) begin
         count_d = 2'd0;
         head_d  = 1'b0;
      end else begin
         if (enq && !deq) count_d = count_q + 2'd1;
         if (!enq && deq) count_d = count_q - 2'd1;
         if (deq)         head_d  = ~head_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      drop_d     = drop_q;
      next_fetch = fetch_pc_q;
      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               fetch_pc_d = target;
               req_addr_d = target;
               state_d    = S_REQ;
            end else if (count_q < 2'd2) begin
               req_addr_d = fetch_pc_q;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (redirect) begin
               fetch_pc_d = target;
               drop_d     = 1'b1;
            end
            if (bus.mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (redirect) begin
               fetch_pc_d = target;
               if (bus.mem_resp_valid) begin
                  drop_d     = 1'b0;
                  req_addr_d = target;
                  state_d    = S_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (bus.mem_resp_valid) begin
               // A dropped response leaves fetch_pc at the redirect target.
               if (drop_q) begin
                  drop_d = 1'b0;
               end else begin
                  next_fetch = pred_pc;
               end
               fetch_pc_d = next_fetch;
               if (count_d < 2'd2) begin
                  req_addr_d = next_fetch;
                  state_d    = S_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= '0;
         drop_q     <= 1'b0;
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_inst_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         head_q     <= head_d;
         if (enq) begin
            fifo_pc_q[wr_ptr]   <= req_addr_q;
            fifo_inst_q[wr_ptr] <= bus.mem_resp_data;
         end
      end
   end

   assign bus.mem_req_valid  = (state_q == S_REQ);
   assign bus.mem_req_addr   = req_addr_q;
   assign bus.mem_resp_ready = 1'b1;
   assign bus.out_valid      = out_valid_w;
   assign bus.out_pc         = fifo_pc_q[head_q];
   assign bus.out_inst       = fifo_inst_q[head_q];
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed bench for the IFU: a latency-programmable instruction memory, a dequeue
// monitor, and one task per scenario with hand-computed expectations.
module tb_ysyx_23060203_ifu;
   localparam logic [31:0] RST_PC = 32'h3000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_dnpc = '0;
   logic        jump_flush = 1'b0;
   logic [31:0] jump_dnpc = '0;
   logic [1:0]  dbg_state;

   ysyx_23060203_ifu_if bus();

   ysyx_23060203_ifu #(.RESET_PC(RST_PC)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .flush_dnpc  (flush_dnpc),
      .jump_flush  (jump_flush),
      .jump_dnpc   (jump_dnpc),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [31:0] imem [logic [31:0]];
   logic [31:0] req_log[$];
   logic [31:0] deq_pc_q[$];
   logic [31:0] deq_inst_q[$];
   int          mem_lat = 0;

   // Memory model: logs accepted addresses, answers mem_lat cycles after a zero-wait reply.
   initial begin
      bit          fire;
      bit          pend;
      int          pend_cnt;
      logic [31:0] fa;
      logic [31:0] pend_addr;
      pend = 0;
      pend_cnt = 0;
      pend_addr = '0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(posedge clock);
         fire = bus.mem_req_valid && bus.mem_req_ready && !reset;
         fa   = bus.mem_req_addr;
         #1;
         bus.mem_resp_valid = 1'b0;
         if (reset) begin
            pend = 0;
         end else if (fire) begin
            req_log.push_back(fa);
            if (mem_lat == 0) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_data  = imem.exists(fa) ? imem[fa] : NOP;
            end else begin
               pend = 1;
               pend_cnt = mem_lat;
               pend_addr = fa;
            end
         end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               pend = 0;
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_data  = imem.exists(pend_addr) ? imem[pend_addr] : NOP;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         if (!reset && bus.out_valid && bus.out_ready) begin
            deq_pc_q.push_back(bus.out_pc);
            deq_inst_q.push_back(bus.out_inst);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush = 1'b0;
      jump_flush = 1'b0;
      repeat (2) step();
      req_log.delete();
      deq_pc_q.delete();
      deq_inst_q.delete();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.mem_req_ready = 1'b0;
      bus.out_ready = 1'b1;
      mem_lat = 0;
      #1 reset = 1'b1;
      step();
      total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", bus.mem_req_valid); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc); end
      total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL rst_out_inst got=%h exp=0", bus.out_inst); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
      reset = 1'b0;
      step();
      total++; if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b exp=1", bus.mem_req_valid); end
      total++; if (bus.mem_req_addr !== RST_PC) begin bad++; $display("FAIL first_req_addr got=%h exp=%h", bus.mem_req_addr, RST_PC); end
      bus.mem_req_ready = 1'b1;
      mem_lat = 3;
      step();
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL wait_state got=%0d exp=2", dbg_state); end
      #1 reset = 1'b1;
      #1;
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL async_rst_state got=%0d exp=0", dbg_state); end
      total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL async_rst_req got=%b exp=0", bus.mem_req_valid); end
      mem_lat = 0;
   endtask

   task automatic test_sequential();
      imem.delete();
      mem_lat = 0;
      bus.mem_req_ready = 1'b1;
      bus.out_ready = 1'b1;
      do_reset();
      step();
      total++; if (bus.mem_req_addr !== RST_PC || bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL seq_req0 got=%h/%b exp=%h/1", bus.mem_req_addr, bus.mem_req_valid, RST_PC); end
      step();
      step();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL seq_out_valid got=%b exp=1", bus.out_valid); end
      total++; if (bus.out_pc !== RST_PC) begin bad++; $display("FAIL seq_out_pc got=%h exp=%h", bus.out_pc, RST_PC); end
      total++; if (bus.out_inst !== NOP) begin bad++; $display("FAIL seq_out_inst got=%h exp=%h", bus.out_inst, NOP); end
      total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h3000_0004) begin bad++; $display("FAIL seq_next_req got=%h/%b exp=30000004/1", bus.mem_req_addr, bus.mem_req_valid); end
      repeat (6) step();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (req_log.size() <= i || req_log[i] !== RST_PC + 32'(4 * i)) begin
            bad++; $display("FAIL seq_req_log[%0d] got=%h exp=%h", i, (req_log.size() > i) ? req_log[i] : 32'hx, RST_PC + 32'(4 * i));
         end
         total++;
         if (deq_pc_q.size() <= i || deq_pc_q[i] !== RST_PC + 32'(4 * i) || deq_inst_q[i] !== NOP) begin
            bad++; $display("FAIL seq_deq[%0d] got_pc=%h exp_pc=%h", i, (deq_pc_q.size() > i) ? deq_pc_q[i] : 32'hx, RST_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      imem.delete();
      mem_lat = 0;
      bus.mem_req_ready = 1'b1;
      bus.out_ready = 1'b0;
      do_reset();
      repeat (12) step();
      total++; if (req_log.size() !== 2) begin bad++; $display("FAIL bp_req_count got=%0d exp=2", req_log.size()); end
      total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b exp=0", bus.mem_req_valid); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL bp_state got=%0d exp=0", dbg_state); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RST_PC) begin bad++; $display("FAIL bp_head got=%h/%b exp=%h/1", bus.out_pc, bus.out_valid, RST_PC); end
      total++; if (deq_pc_q.size() !== 0) begin bad++; $display("FAIL bp_no_deq got=%0d exp=0", deq_pc_q.size()); end
      bus.out_ready = 1'b1;
      repeat (14) step();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (deq_pc_q.size() <= i || deq_pc_q[i] !== RST_PC + 32'(4 * i)) begin
            bad++; $display("FAIL bp_drain[%0d] got=%h exp=%h", i, (deq_pc_q.size() > i) ? deq_pc_q[i] : 32'hx, RST_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_predict();
      logic [31:0] exp_b [5];
      imem.delete();
      imem[RST_PC] = 32'h0100_006F;
      imem[32'h3000_0010] = 32'h0000_0463;
      mem_lat = 0;
      bus.mem_req_ready = 1'b1;
      bus.out_ready = 1'b1;
      do_reset();
      repeat (10) step();
      total++; if (req_log.size() < 2 || req_log[1] !== 32'h3000_0010) begin bad++; $display("FAIL jal_target got=%h exp=30000010", (req_log.size() > 1) ? req_log[1] : 32'hx); end
      total++; if (req_log.size() < 3 || req_log[2] !== 32'h3000_0014) begin bad++; $display("FAIL fwd_branch got=%h exp=30000014", (req_log.size() > 2) ? req_log[2] : 32'hx); end
      imem.delete();
      imem[32'h3000_0008] = 32'hFE00_0EE3;
      do_reset();
      repeat (14) step();
      exp_b[0] = 32'h3000_0000; exp_b[1] = 32'h3000_0004; exp_b[2] = 32'h3000_0008;
      exp_b[3] = 32'h3000_0004; exp_b[4] = 32'h3000_0008;
      for (int i = 2; i < 5; i++) begin
         total++;
         if (req_log.size() <= i || req_log[i] !== exp_b[i]) begin
            bad++; $display("FAIL bwd_branch[%0d] got=%h exp=%h", i, (req_log.size() > i) ? req_log[i] : 32'hx, exp_b[i]);
         end
      end
   endtask

   task automatic test_jump_flush_wait();
      bit found;
      imem.delete();
      mem_lat = 3;
      bus.mem_req_ready = 1'b1;
      bus.out_ready = 1'b0;
      do_reset();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (dbg_state == 2'd2 && bus.out_valid) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL jf_reach_wait got=0 exp=1"); end
      jump_flush = 1'b1;
      jump_dnpc = 32'h3000_0100;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jf_out_valid_same_cycle got=%b exp=0", bus.out_valid); end
      step();
      jump_flush = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jf_fifo_cleared got=%b exp=0", bus.out_valid); end
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL jf_still_wait got=%0d exp=2", dbg_state); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && deq_pc_q.size() == 0; i++) step();
      total++; if (req_log.size() < 3 || req_log[2] !== 32'h3000_0100) begin bad++; $display("FAIL jf_target_req got=%h exp=30000100", (req_log.size() > 2) ? req_log[2] : 32'hx); end
      total++; if (deq_pc_q.size() < 1 || deq_pc_q[0] !== 32'h3000_0100) begin bad++; $display("FAIL jf_first_deq got=%h exp=30000100", (deq_pc_q.size() > 0) ? deq_pc_q[0] : 32'hx); end
      mem_lat = 0;
   endtask

   task automatic test_flush_priority();
      imem.delete();
      imem[32'h3000_0200] = 32'h0010_0093;
      mem_lat = 0;
      bus.mem_req_ready = 1'b1;
      bus.out_ready = 1'b0;
      do_reset();
      repeat (10) step();
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL fp_idle got=%0d exp=0", dbg_state); end
      flush = 1'b1;
      flush_dnpc = 32'h3000_0200;
      jump_flush = 1'b1;
      jump_dnpc = 32'h3000_0100;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fp_out_valid got=%b exp=0", bus.out_valid); end
      step();
      flush = 1'b0;
      jump_flush = 1'b0;
      total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h3000_0200) begin bad++; $display("FAIL fp_req got=%h/%b exp=30000200/1", bus.mem_req_addr, bus.mem_req_valid); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fp_fifo_cleared got=%b exp=0", bus.out_valid); end
      bus.out_ready = 1'b1;
      repeat (4) step();
      total++; if (deq_pc_q.size() < 1 || deq_pc_q[0] !== 32'h3000_0200 || deq_inst_q[0] !== 32'h0010_0093) begin
         bad++; $display("FAIL fp_deq got=%h exp=30000200", (deq_pc_q.size() > 0) ? deq_pc_q[0] : 32'hx);
      end
   endtask

   task automatic test_redirect_req();
      imem.delete();
      mem_lat = 0;
      bus.mem_req_ready = 1'b0;
      bus.out_ready = 1'b1;
      do_reset();
      step();
      jump_flush = 1'b1;
      jump_dnpc = 32'h3000_0100;
      step();
      jump_flush = 1'b0;
      total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RST_PC) begin bad++; $display("FAIL rr_hold1 got=%h/%b exp=%h/1", bus.mem_req_addr, bus.mem_req_valid, RST_PC); end
      step();
      total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RST_PC) begin bad++; $display("FAIL rr_hold2 got=%h/%b exp=%h/1", bus.mem_req_addr, bus.mem_req_valid, RST_PC); end
      bus.mem_req_ready = 1'b1;
      repeat (8) step();
      total++; if (req_log.size() < 1 || req_log[0] !== RST_PC) begin bad++; $display("FAIL rr_old_req got=%h exp=%h", (req_log.size() > 0) ? req_log[0] : 32'hx, RST_PC); end
      total++; if (req_log.size() < 2 || req_log[1] !== 32'h3000_0100) begin bad++; $display("FAIL rr_target_req got=%h exp=30000100", (req_log.size() > 1) ? req_log[1] : 32'hx); end
      total++; if (deq_pc_q.size() < 1 || deq_pc_q[0] !== 32'h3000_0100) begin bad++; $display("FAIL rr_dropped got=%h exp=30000100", (deq_pc_q.size() > 0) ? deq_pc_q[0] : 32'hx); end
   endtask

   initial begin
      bus.mem_req_ready = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_predict();
      test_jump_flush_wait();
      test_flush_priority();
      test_redirect_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
